// File: rtl/seg7_display.sv
// seg7_display: captures an 8-bit value, converts it to BCD with a double-dabble engine,
// and scans a 4-digit common-cathode display. Define SIGNED_MODE_EN for two's-complement input with a minus sign.
module seg7_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  din,
  input  logic        load,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        neg,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  state_t      state_q;
  logic [7:0]  operand_q;
  logic [11:0] scratch_q;
  logic [2:0]  step_q;
  logic [11:0] bcd_q;
  logic [PW-1:0] presc_q;
  logic [1:0]  idx_q;

  logic [7:0]  mag_d;
  logic [11:0] adj_d;
  logic [19:0] shift_d;

`ifdef SIGNED_MODE_EN
  logic sign_pend_q;
  logic neg_q;
  assign mag_d = din[7] ? 8'(-din) : din;
  assign neg   = neg_q;
`else
  assign mag_d = din;
  assign neg   = 1'b0;
`endif

  always_comb begin
    adj_d = scratch_q;
    for (int i = 0; i < 3; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  // The hundreds nibble never exceeds 2, so the bit shifted out of the top is always 0.
  assign shift_d = {adj_d, operand_q} << 1;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      operand_q <= '0;
      scratch_q <= '0;
      step_q    <= '0;
      bcd_q     <= '0;
`ifdef SIGNED_MODE_EN
      sign_pend_q <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      if (state_q == SHIFT) begin
        operand_q <= shift_d[7:0];
        scratch_q <= shift_d[19:8];
        step_q    <= step_q + 3'd1;
        if (step_q == 3'd7) begin
          bcd_q   <= shift_d[19:8];
`ifdef SIGNED_MODE_EN
          neg_q   <= sign_pend_q;
`endif
          state_q <= IDLE;
        end
      end
      // A new load overrides the shift updates above; a commit on the same edge still lands.
      if (load) begin
        operand_q <= mag_d;
        scratch_q <= '0;
        step_q    <= '0;
`ifdef SIGNED_MODE_EN
        sign_pend_q <= din[7];
`endif
        state_q   <= SHIFT;
      end
    end
  end

  assign busy = (state_q == SHIFT);
  assign bcd  = bcd_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  always_comb begin
    an  = 4'b0001 << idx_q;
    seg = 7'h00;
    case (idx_q)
      2'd0: seg = glyph(bcd_q[3:0]);
      2'd1: seg = (bcd_q[11:4] == 8'd0) ? 7'h00 : glyph(bcd_q[7:4]);
      2'd2: seg = (bcd_q[11:8] == 4'd0) ? 7'h00 : glyph(bcd_q[11:8]);
`ifdef SIGNED_MODE_EN
      2'd3: seg = neg_q ? 7'h40 : 7'h00;
`else
      2'd3: seg = 7'h00;
`endif
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: tb/tb_seg7_display.sv
// tb_seg7_display: directed and randomized checks of seg7_display against a decimal/timing
// reference model. Follows SIGNED_MODE_EN the same way the design does.
module tb_seg7_display;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        load = 1'b0;
  logic        busy;
  logic [11:0] bcd;
  logic        neg;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  // Reference model state: committed value, pending value, cycles left until commit.
  int cyc = 0;
  int m_val = 0;
  bit m_neg = 1'b0;
  int m_pval = 0;
  bit m_pneg = 1'b0;
  int m_rem = 0;

  seg7_display #(.SCAN_DIV(SD)) dut (
    .clk(clk), .clr(clr), .din(din), .load(load),
    .busy(busy), .bcd(bcd), .neg(neg), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic int mag(input logic [7:0] v);
`ifdef SIGNED_MODE_EN
    return v[7] ? 256 - int'(v) : int'(v);
`else
    return int'(v);
`endif
  endfunction

  function automatic bit sgn(input logic [7:0] v);
`ifdef SIGNED_MODE_EN
    return v[7];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] exp_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input int v, input bit ng);
    case (idx)
      0: return glyph(v % 10);
      1: return (v < 10) ? 7'h00 : glyph((v / 10) % 10);
      2: return (v < 100) ? 7'h00 : glyph(v / 100);
      default: return ng ? 7'h40 : 7'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      cyc <= 0; m_rem <= 0; m_val <= 0; m_neg <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (load) begin
        if (m_rem == 1) begin m_val <= m_pval; m_neg <= m_pneg; end
        m_pval <= mag(din);
        m_pneg <= sgn(din);
        m_rem  <= 8;
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin m_val <= m_pval; m_neg <= m_pneg; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    din = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b required 0 within 20 cycles", name, busy);
    end
  endtask

  task automatic test_reset();
    logic [3:0] an_seq [8] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    clr = 1'b1; load = 1'b0;
    tick(); tick();
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h required 000", bcd); end
    if (neg !== 1'b0) begin errors++; $display("FAIL reset_neg: got %b required 0", neg); end
    if (an !== 4'b0001) begin errors++; $display("FAIL reset_an: got %b required 0001", an); end
    if (seg !== 7'h3F) begin errors++; $display("FAIL reset_seg: got %h required 3F", seg); end
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (an !== an_seq[i]) begin
        errors++; $display("FAIL scan_seq[%0d]: an=%b required %b", i, an, an_seq[i]);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [6:0] tbl [4] = '{7'h6D, 7'h6D, 7'h5B, 7'h00};
    int idx;
    do_load(8'hFF);
    checks++;
    if (bcd !== 12'h000) begin errors++; $display("FAIL hold_bcd: got %h required 000", bcd); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_high[%0d]: got %b required 1", i, busy); end
    end
    tick();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b required 0", busy); end
    if (bcd !== 12'h255) begin errors++; $display("FAIL bcd_255: got %h required 255", bcd); end
    for (int i = 0; i < 8; i++) begin
      tick();
      idx = (cyc / SD) % 4;
      checks += 2;
      if (an !== 4'(1 << idx)) begin errors++; $display("FAIL scan_an_255: got %b required %b", an, 4'(1 << idx)); end
      if (seg !== tbl[idx]) begin errors++; $display("FAIL seg_255[%0d]: got %h required %h", idx, seg, tbl[idx]); end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] tbl [4] = '{7'h07, 7'h00, 7'h00, 7'h00};
    int idx;
    do_load(8'h07);
    wait_idle("blank7");
    checks++;
    if (bcd !== 12'h007) begin errors++; $display("FAIL bcd_007: got %h required 007", bcd); end
    for (int i = 0; i < 8; i++) begin
      tick();
      idx = (cyc / SD) % 4;
      checks++;
      if (seg !== tbl[idx]) begin errors++; $display("FAIL seg_007[%0d]: got %h required %h", idx, seg, tbl[idx]); end
    end
    do_load(8'h00);
    wait_idle("blank0");
    for (int i = 0; i < 8; i++) begin
      tick();
      idx = (cyc / SD) % 4;
      checks++;
      if (seg !== ((idx == 0) ? 7'h3F : 7'h00)) begin
        errors++; $display("FAIL seg_000[%0d]: got %h required %h", idx, seg, (idx == 0) ? 7'h3F : 7'h00);
      end
    end
  endtask

  task automatic test_restart();
    do_load(8'h64);
    tick(); tick();
    do_load(8'h0A);
    for (int i = 1; i < 8; i++) begin
      tick();
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy[%0d]: got %b required 1", i, busy); end
      if (bcd === 12'h100) begin errors++; $display("FAIL restart_abort: got bcd %h required not 100", bcd); end
    end
    tick();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL restart_fall: got %b required 0", busy); end
    if (bcd !== 12'h010) begin errors++; $display("FAIL restart_bcd: got %h required 010", bcd); end
  endtask

  task automatic test_back_to_back();
    do_load(8'h2A);
    for (int i = 1; i < 8; i++) tick();
    do_load(8'hC8);
    checks += 2;
    if (bcd !== exp_bcd(mag(8'h2A))) begin errors++; $display("FAIL b2b_first: got %h required %h", bcd, exp_bcd(mag(8'h2A))); end
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b required 1", busy); end
    for (int i = 1; i < 8; i++) tick();
    tick();
    checks++;
    if (bcd !== exp_bcd(mag(8'hC8))) begin errors++; $display("FAIL b2b_second: got %h required %h", bcd, exp_bcd(mag(8'hC8))); end
  endtask

  task automatic test_mid_clr();
    do_load(8'hFF);
    wait_idle("midclr_pre");
    checks++;
    if (bcd !== 12'h255) begin errors++; $display("FAIL midclr_pre: got %h required 255", bcd); end
    do_load(8'hC8);
    tick(); tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL midclr_busy: got %b required 0", busy); end
    if (bcd !== 12'h000) begin errors++; $display("FAIL midclr_bcd: got %h required 000", bcd); end
    if (an !== 4'b0001) begin errors++; $display("FAIL midclr_an: got %b required 0001", an); end
    if (seg !== 7'h3F) begin errors++; $display("FAIL midclr_seg: got %h required 3F", seg); end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (bcd !== 12'h000 || busy !== 1'b0) begin
        errors++; $display("FAIL midclr_late[%0d]: bcd=%h busy=%b required 000/0", i, bcd, busy);
      end
    end
  endtask

`ifdef SIGNED_MODE_EN
  task automatic test_signed();
    logic [7:0]  vin [3] = '{8'h80, 8'hF6, 8'h7F};
    logic [11:0] vb  [3] = '{12'h128, 12'h010, 12'h127};
    bit          vn  [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      do_load(vin[k]);
      wait_idle("signed");
      checks += 2;
      if (bcd !== vb[k]) begin errors++; $display("FAIL signed_bcd[%0d]: got %h required %h", k, bcd, vb[k]); end
      if (neg !== vn[k]) begin errors++; $display("FAIL signed_neg[%0d]: got %b required %b", k, neg, vn[k]); end
      for (int i = 0; i < 8; i++) begin
        tick();
        if ((cyc / SD) % 4 == 3) begin
          checks++;
          if (seg !== (vn[k] ? 7'h40 : 7'h00)) begin
            errors++; $display("FAIL signed_digit3[%0d]: got %h required %h", k, seg, vn[k] ? 7'h40 : 7'h00);
          end
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    int idx;
    for (int i = 0; i < 600; i++) begin
      clr  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 5) == 0);
      din  = 8'($urandom);
      tick();
      idx = (cyc / SD) % 4;
      checks += 5;
      if (busy !== (m_rem != 0)) begin errors++; $display("FAIL rnd_busy[%0d]: got %b required %b", i, busy, m_rem != 0); end
      if (bcd !== exp_bcd(m_val)) begin errors++; $display("FAIL rnd_bcd[%0d]: got %h required %h", i, bcd, exp_bcd(m_val)); end
      if (neg !== m_neg) begin errors++; $display("FAIL rnd_neg[%0d]: got %b required %b", i, neg, m_neg); end
      if (an !== 4'(1 << idx)) begin errors++; $display("FAIL rnd_an[%0d]: got %b required %b", i, an, 4'(1 << idx)); end
      if (seg !== exp_seg(idx, m_val, m_neg)) begin
        errors++; $display("FAIL rnd_seg[%0d]: got %h required %h", i, seg, exp_seg(idx, m_val, m_neg));
      end
    end
    clr = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_blanking();
    test_restart();
    test_back_to_back();
    test_mid_clr();
`ifdef SIGNED_MODE_EN
    test_signed();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
